// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: opcode/memory-ready inputs and datapath control outputs of the multicycle control unit
interface multicycle_control_fsm_if #(parameter int OP_W = 5, parameter int CNT_W = 32);
  logic [OP_W-1:0] Op;
  logic mem_ready;
  logic PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic instr_done;
  logic [CNT_W-1:0] instr_count;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
  modport master (output Op, mem_ready,
    input PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcB,
    ALUSrcA, RegWrite, RegDst, state, instr_done, instr_count, illegal_op);
  modport slave (input Op, mem_ready,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcB,
    ALUSrcA, RegWrite, RegDst, state, instr_done, instr_count, illegal_op);
`else
  modport master (output Op, mem_ready,
    input PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcB,
    ALUSrcA, RegWrite, RegDst, state, instr_done, instr_count);
  modport slave (input Op, mem_ready,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcB,
    ALUSrcA, RegWrite, RegDst, state, instr_done, instr_count);
`endif
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS control unit with memory-ready waits and retire counter; ILLEGAL_OP_TRAP_EN adds a TRAP state
module multicycle_control_fsm #(
  parameter int OP_W = 5,
  parameter logic [OP_W-1:0] OP_RTYPE = 0,
  parameter logic [OP_W-1:0] OP_LW = 1,
  parameter logic [OP_W-1:0] OP_SW = 2,
  parameter logic [OP_W-1:0] OP_BEQ = 3,
  parameter logic [OP_W-1:0] OP_J = 4,
  parameter logic [OP_W-1:0] OP_ADDI = 5,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  multicycle_control_fsm_if.slave bus
);
`ifdef ILLEGAL_OP_TRAP_EN
  typedef enum logic [3:0] {FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6,
    ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11, TRAP = 12} stateT;
  localparam stateT BAD_NEXT = TRAP;
`else
  typedef enum logic [3:0] {FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6,
    ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11} stateT;
  localparam stateT BAD_NEXT = FETCH;
`endif
  typedef struct packed {
    logic pcWriteCond, pcWrite, iorD, memRead, memWrite, memtoReg, irWrite;
    logic [1:0] pcSource, aluOp, aluSrcB;
    logic aluSrcA, regWrite, regDst;
  } ctlT;
  stateT stateQ, stateD;
  ctlT ctl;
  logic done;
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= FETCH;
      count <= '0;
    end else begin
      stateQ <= stateD;
      if (done) count <= count + CNT_W'(1);
    end
  end
  always_comb begin
    ctl = '0;
    done = 1'b0;
    stateD = stateQ;
    case (stateQ)
      FETCH: begin
        ctl.memRead = 1'b1;
        ctl.aluSrcB = 2'b01;
        ctl.irWrite = bus.mem_ready;
        ctl.pcWrite = bus.mem_ready;
        stateD = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctl.aluSrcB = 2'b11;
        stateD = (bus.Op == OP_LW || bus.Op == OP_SW) ? MEMADR :
                 bus.Op == OP_RTYPE ? EXEC :
                 bus.Op == OP_BEQ ? BRANCH :
                 bus.Op == OP_J ? JUMP :
                 bus.Op == OP_ADDI ? ADDIEX : BAD_NEXT;
      end
      MEMADR: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluSrcB = 2'b10;
        stateD = bus.Op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctl.memRead = 1'b1;
        ctl.iorD = 1'b1;
        stateD = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctl.memtoReg = 1'b1;
        ctl.regWrite = 1'b1;
        done = 1'b1;
        stateD = FETCH;
      end
      MEMWR: begin
        ctl.memWrite = 1'b1;
        ctl.iorD = 1'b1;
        done = bus.mem_ready;
        stateD = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluOp = 2'b10;
        stateD = ALUWB;
      end
      ALUWB: begin
        ctl.regDst = 1'b1;
        ctl.regWrite = 1'b1;
        done = 1'b1;
        stateD = FETCH;
      end
      BRANCH: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluOp = 2'b01;
        ctl.pcSource = 2'b01;
        ctl.pcWriteCond = 1'b1;
        done = 1'b1;
        stateD = FETCH;
      end
      JUMP: begin
        ctl.pcSource = 2'b10;
        ctl.pcWrite = 1'b1;
        done = 1'b1;
        stateD = FETCH;
      end
      ADDIEX: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluSrcB = 2'b10;
        stateD = ADDIWB;
      end
      ADDIWB: begin
        ctl.regWrite = 1'b1;
        done = 1'b1;
        stateD = FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: stateD = TRAP;
`endif
      default: stateD = FETCH;
    endcase
  end
  // reset masks every control output so a held rst never drives the datapath
  assign {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
          bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite, bus.RegDst} = rst ? '0 : ctl;
  assign bus.instr_done = done & ~rst;
  assign bus.state = stateQ;
  assign bus.instr_count = count;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op = (stateQ == TRAP) & ~rst;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle vectors pushed to a scoreboard queue, checked by a negedge monitor
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multicycle_control_fsm_if #(.OP_W(5), .CNT_W(4)) bus ();
  multicycle_control_fsm #(.OP_W(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  // control vector: PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite | PCSource | ALUOp | ALUSrcB | ALUSrcA,RegWrite,RegDst
  localparam logic [15:0] F1   = {7'b0101001, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [15:0] F0   = {7'b0001000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [15:0] DEC  = {7'b0000000, 2'b00, 2'b00, 2'b11, 3'b000};
  localparam logic [15:0] MADR = {7'b0000000, 2'b00, 2'b00, 2'b10, 3'b100};
  localparam logic [15:0] MRD  = {7'b0011000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] MWB  = {7'b0000010, 2'b00, 2'b00, 2'b00, 3'b010};
  localparam logic [15:0] MWR  = {7'b0010100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] EXE  = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b100};
  localparam logic [15:0] AWB  = {7'b0000000, 2'b00, 2'b00, 2'b00, 3'b011};
  localparam logic [15:0] BR   = {7'b1000000, 2'b01, 2'b01, 2'b00, 3'b100};
  localparam logic [15:0] JMP  = {7'b0100000, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] AIWB = {7'b0000000, 2'b00, 2'b00, 2'b00, 3'b010};
  typedef struct {logic [3:0] st; logic [15:0] c; logic d; logic [3:0] n; logic il;} expT;
  expT q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      expT e;
      e = q.pop_front();
      chk("state", 16'(bus.state), 16'(e.st));
      chk("ctl", {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
                  bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite, bus.RegDst}, e.c);
      chk("instr_done", 16'(bus.instr_done), 16'(e.d));
      chk("instr_count", 16'(bus.instr_count), 16'(e.n));
`ifdef ILLEGAL_OP_TRAP_EN
      chk("illegal_op", 16'(bus.illegal_op), 16'(e.il));
`endif
      cyc++;
    end
  end
  task automatic step(input logic r, input logic [4:0] op, input logic mr, input logic [3:0] st,
                      input logic [15:0] c, input logic d, input logic [3:0] n, input logic il = 1'b0);
    expT e;
    rst = r;
    bus.Op = op;
    bus.mem_ready = mr;
    e.st = st; e.c = c; e.d = d; e.n = n; e.il = il;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.Op = '0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 1, 0, 16'h0, 0, 0);
    step(1, 1, 1, 0, 16'h0, 0, 0);
    step(0, 1, 1, 0, F1, 0, 0);
    step(0, 1, 1, 1, DEC, 0, 0);
    step(0, 1, 1, 2, MADR, 0, 0);
    step(0, 1, 1, 3, MRD, 0, 0);
    step(0, 1, 1, 4, MWB, 1, 0);
    step(0, 2, 1, 0, F1, 0, 1);
    step(0, 2, 0, 1, DEC, 0, 1);
    step(0, 2, 0, 2, MADR, 0, 1);
    step(0, 2, 0, 5, MWR, 0, 1);
    step(0, 2, 0, 5, MWR, 0, 1);
    step(0, 2, 0, 5, MWR, 0, 1);
    step(0, 2, 1, 5, MWR, 1, 1);
    step(0, 3, 0, 0, F0, 0, 2);
    step(0, 3, 1, 0, F1, 0, 2);
    step(0, 3, 1, 1, DEC, 0, 2);
    step(0, 3, 1, 8, BR, 1, 2);
    step(0, 4, 1, 0, F1, 0, 3);
    step(0, 4, 1, 1, DEC, 0, 3);
    step(0, 4, 1, 9, JMP, 1, 3);
    step(0, 5, 1, 0, F1, 0, 4);
    step(0, 5, 1, 1, DEC, 0, 4);
    step(0, 5, 1, 10, MADR, 0, 4);
    step(0, 5, 1, 11, AIWB, 1, 4);
    step(0, 0, 1, 0, F1, 0, 5);
    step(0, 0, 1, 1, DEC, 0, 5);
    step(1, 0, 1, 6, 16'h0, 0, 5);
    step(0, 0, 1, 0, F1, 0, 0);
    step(0, 0, 1, 1, DEC, 0, 0);
    step(0, 0, 1, 6, EXE, 0, 0);
    step(0, 0, 1, 7, AWB, 1, 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 4, 1, 0, F1, 0, 4'(i));
      step(0, 4, 1, 1, DEC, 0, 4'(i));
      step(0, 4, 1, 9, JMP, 1, 4'(i));
    end
    step(0, 5'h1F, 1, 0, F1, 0, 0);
    step(0, 5'h1F, 1, 1, DEC, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    step(0, 5'h1F, 0, 12, 16'h0, 0, 0, 1);
    step(0, 5'h1F, 1, 12, 16'h0, 0, 0, 1);
    step(1, 5'h1F, 1, 12, 16'h0, 0, 0, 0);
    step(0, 0, 1, 0, F1, 0, 0);
`else
    step(0, 5'h1F, 0, 0, F0, 0, 0);
`endif
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
